// File: rtl/parser_pkg.sv
// Message classification types shared by the UART RX parser and the register
// sequencer, plus the field widths of a parsed register message.
package parser_pkg;

  typedef enum logic [2:0] {
    MSG_NONE      = 3'd0,
    MSG_REG_WRITE = 3'd1,
    MSG_REG_READ  = 3'd2,
    MSG_PIXEL     = 3'd3,
    MSG_BURST     = 3'd4
  } msg_type_e;

  localparam int SEL_W   = 8;
  localparam int OFS_W   = 16;
  localparam int HALF_W  = 16;
  localparam int WORD_W  = 2 * HALF_W;
  localparam int ERRC_W  = 8;

  function automatic logic is_reg_type(input msg_type_e t);
    return (t == MSG_REG_WRITE) || (t == MSG_REG_READ);
  endfunction

endpackage

// File: rtl/uart_reg_sequencer.sv
// Register-access sequencer: turns one parsed UART register message into a
// single req/ack bus transaction and hands read results back to the TX path.
module uart_reg_sequencer
  import parser_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic              clk_sys,
  input  logic              rst_sys_n,
  input  logic              sys_data_available,
  input  logic              sys_valid_msg,
  input  msg_type_e         sys_classified_type,
  input  logic [SEL_W-1:0]  sys_parsed_addr,
  input  logic [OFS_W-1:0]  sys_parsed_offset_addr,
  input  logic [HALF_W-1:0] sys_parsed_data_high,
  input  logic [HALF_W-1:0] sys_parsed_data_low,
  output logic              sys_seq_ready,
  output logic              rgf_req,
  output logic              rgf_wr,
  output logic [SEL_W-1:0]  rgf_sel,
  output logic [OFS_W-1:0]  rgf_addr,
  output logic [WORD_W-1:0] rgf_wdata,
  input  logic              rgf_ack,
  input  logic [WORD_W-1:0] rgf_rdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              rsp_ready,
  output logic              err_pulse,
  output logic [ERRC_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    BUS    = 3'd2,
    RESP   = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e state;
  state_e state_nxt;

  msg_type_e          shd_type;
  logic               shd_valid;
  logic [SEL_W-1:0]   shd_sel;
  logic [OFS_W-1:0]   shd_offset;
  logic [WORD_W-1:0]  shd_wdata;

  logic [TMO_W-1:0]   tmo_cnt;
  logic [WORD_W-1:0]  rsp_data_q;
  logic               rsp_err_q;
  logic               err_pulse_q;
  logic [ERRC_W-1:0]  err_cnt_q;
  logic               rearm_wait;

  logic shd_is_write;
  logic capture;
  logic ack_hit;
  logic tmo_hit;
  logic decode_err;
  logic err_evt;

  function automatic logic [ERRC_W-1:0] sat_inc(input logic [ERRC_W-1:0] v);
    return (v == {ERRC_W{1'b1}}) ? v : v + ERRC_W'(1);
  endfunction

  assign shd_is_write = (shd_type == MSG_REG_WRITE);
  assign capture      = (state == IDLE) && (state_nxt == DECODE);
  // An ack on the final timeout cycle wins over the timeout.
  assign ack_hit      = (state == BUS) && rgf_ack;
  assign tmo_hit      = (state == BUS) && !rgf_ack && (tmo_cnt == TMO_LAST);
  assign decode_err   = (state == DECODE) && is_reg_type(shd_type) && !shd_valid;
  assign err_evt      = decode_err || tmo_hit;

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (sys_data_available && !sys_seq_ready && !rearm_wait) begin
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        if (!is_reg_type(shd_type)) begin
          state_nxt = IDLE;
        end else if (shd_valid) begin
          state_nxt = BUS;
        end else begin
          state_nxt = DONE;
        end
      end
      BUS: begin
        if (ack_hit || tmo_hit) begin
          state_nxt = shd_is_write ? DONE : RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (!sys_data_available) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rgf_req       = 1'b0;
    rgf_wr        = 1'b0;
    rgf_sel       = '0;
    rgf_addr      = '0;
    rgf_wdata     = '0;
    rsp_valid     = 1'b0;
    sys_seq_ready = 1'b0;
    if (state == BUS) begin
      rgf_req   = 1'b1;
      rgf_wr    = shd_is_write;
      rgf_sel   = shd_sel;
      rgf_addr  = shd_offset;
      rgf_wdata = shd_wdata;
    end
    if (state == RESP) begin
      rsp_valid = 1'b1;
    end
    if (state == DONE) begin
      sys_seq_ready = 1'b1;
    end
    rsp_data  = rsp_data_q;
    rsp_err   = rsp_err_q;
    err_pulse = err_pulse_q;
    err_cnt   = err_cnt_q;
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      shd_type   <= MSG_NONE;
      shd_valid  <= 1'b0;
      shd_sel    <= '0;
      shd_offset <= '0;
      shd_wdata  <= '0;
    end else if (capture) begin
      shd_type   <= sys_classified_type;
      shd_valid  <= sys_valid_msg;
      shd_sel    <= sys_parsed_addr;
      shd_offset <= sys_parsed_offset_addr;
      shd_wdata  <= {sys_parsed_data_high, sys_parsed_data_low};
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      tmo_cnt <= '0;
    end else if (state == DECODE) begin
      tmo_cnt <= '0;
    end else if (state == BUS) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Non-register messages are dropped silently; wait for the level to fall
  // so the same message is not decoded twice.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      rearm_wait <= 1'b0;
    end else if ((state == DECODE) && !is_reg_type(shd_type)) begin
      rearm_wait <= 1'b1;
    end else if (!sys_data_available) begin
      rearm_wait <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else if (ack_hit && !shd_is_write) begin
      rsp_data_q <= rgf_rdata;
      rsp_err_q  <= 1'b0;
    end else if (tmo_hit && !shd_is_write) begin
      rsp_data_q <= ERR_DATA;
      rsp_err_q  <= 1'b1;
    end else if ((state == RESP) && rsp_ready) begin
      rsp_err_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_pulse_q <= err_evt;
      if (err_evt) begin
        err_cnt_q <= sat_inc(err_cnt_q);
      end
    end
  end

endmodule

// File: tb/tb_uart_reg_sequencer.sv
// Bench for uart_reg_sequencer: directed vector table, randomized messages
// against a transaction-level model, reset and error-counter saturation runs.
module tb_uart_reg_sequencer;
  import parser_pkg::*;

  localparam int TMO = 16;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n;
  logic        sys_data_available;
  logic        sys_valid_msg;
  msg_type_e   sys_classified_type;
  logic [7:0]  sys_parsed_addr;
  logic [15:0] sys_parsed_offset_addr;
  logic [15:0] sys_parsed_data_high;
  logic [15:0] sys_parsed_data_low;
  logic        sys_seq_ready;
  logic        rgf_req;
  logic        rgf_wr;
  logic [7:0]  rgf_sel;
  logic [15:0] rgf_addr;
  logic [31:0] rgf_wdata;
  logic        rgf_ack;
  logic [31:0] rgf_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_ready;
  logic        err_pulse;
  logic [7:0]  err_cnt;

  uart_reg_sequencer #(
    .TIMEOUT_CYCLES(TMO),
    .ERR_DATA      (32'hDEAD_BEEF)
  ) dut (
    .clk_sys               (clk_sys),
    .rst_sys_n             (rst_sys_n),
    .sys_data_available    (sys_data_available),
    .sys_valid_msg         (sys_valid_msg),
    .sys_classified_type   (sys_classified_type),
    .sys_parsed_addr       (sys_parsed_addr),
    .sys_parsed_offset_addr(sys_parsed_offset_addr),
    .sys_parsed_data_high  (sys_parsed_data_high),
    .sys_parsed_data_low   (sys_parsed_data_low),
    .sys_seq_ready         (sys_seq_ready),
    .rgf_req               (rgf_req),
    .rgf_wr                (rgf_wr),
    .rgf_sel               (rgf_sel),
    .rgf_addr              (rgf_addr),
    .rgf_wdata             (rgf_wdata),
    .rgf_ack               (rgf_ack),
    .rgf_rdata             (rgf_rdata),
    .rsp_valid             (rsp_valid),
    .rsp_data              (rsp_data),
    .rsp_err               (rsp_err),
    .rsp_ready             (rsp_ready),
    .err_pulse             (err_pulse),
    .err_cnt               (err_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    msg_type_e   typ;
    logic        valid;
    logic [7:0]  sel;
    logic [15:0] off;
    logic [15:0] dh;
    logic [15:0] dl;
    int          ack_dly;   // BUS cycle index of the ack; -1 = never
    logic [31:0] rdata;
    int          rdy_dly;   // cycles rsp_ready is held low
  } msg_t;

  typedef struct {
    int          req_cycles; // 0 = no bus request expected
    logic        wr;
    logic [31:0] wdata;
    logic [7:0]  sel;
    logic [15:0] addr;
    logic        resp;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        done;
    logic        err;
  } exp_t;

  typedef struct {
    msg_t m;
    exp_t e;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  int    model_err_cnt = 0;
  string tag = "init";

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL [%s] %s: got %b expected %b", tag, name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL [%s] %s: got %h expected %h", tag, name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Transaction-level expectation of one message, straight from the rules.
  function automatic exp_t model(input msg_t m);
    exp_t e;
    bit   acked;
    e = '{default: 0};
    if (!(m.typ == MSG_REG_WRITE || m.typ == MSG_REG_READ)) return e;
    e.done = 1'b1;
    if (!m.valid) begin
      e.err = 1'b1;
      return e;
    end
    acked        = (m.ack_dly >= 0) && (m.ack_dly < TMO);
    e.req_cycles = acked ? m.ack_dly + 1 : TMO;
    e.wr         = (m.typ == MSG_REG_WRITE);
    e.sel        = m.sel;
    e.addr       = m.off;
    e.wdata      = {m.dh, m.dl};
    e.err        = !acked;
    if (!e.wr) begin
      e.resp     = 1'b1;
      e.rsp_data = acked ? m.rdata : 32'hDEAD_BEEF;
      e.rsp_err  = !acked;
    end
    return e;
  endfunction

  function automatic msg_t rand_msg();
    msg_t m;
    int   k;
    k = int'($urandom_range(0, 9));
    if (k < 4)       m.typ = MSG_REG_WRITE;
    else if (k < 8)  m.typ = MSG_REG_READ;
    else if (k == 8) m.typ = MSG_PIXEL;
    else             m.typ = ($urandom_range(0, 1) == 0) ? MSG_NONE : MSG_BURST;
    m.valid   = ($urandom_range(0, 7) != 0);
    m.sel     = 8'($urandom);
    m.off     = 16'($urandom);
    m.dh      = 16'($urandom);
    m.dl      = 16'($urandom);
    m.ack_dly = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 20));
    m.rdata   = $urandom;
    m.rdy_dly = int'($urandom_range(0, 4));
    return m;
  endfunction

  task automatic scramble_inputs();
    sys_classified_type    = msg_type_e'(3'($urandom_range(0, 4)));
    sys_valid_msg          = 1'($urandom);
    sys_parsed_addr        = 8'($urandom);
    sys_parsed_offset_addr = 16'($urandom);
    sys_parsed_data_high   = 16'($urandom);
    sys_parsed_data_low    = 16'($urandom);
  endtask

  task automatic run_msg(input msg_t m, input exp_t e);
    int          n;
    int          hold;
    bit          bad;
    logic [31:0] d0;
    logic        r0;
    sys_classified_type    = m.typ;
    sys_valid_msg          = m.valid;
    sys_parsed_addr        = m.sel;
    sys_parsed_offset_addr = m.off;
    sys_parsed_data_high   = m.dh;
    sys_parsed_data_low    = m.dl;
    sys_data_available     = 1'b1;
    step();
    chk1("decode_no_req", rgf_req, 1'b0);
    scramble_inputs();
    step();
    chk1("req_latency", rgf_req, e.req_cycles > 0);
    if (e.req_cycles > 0) begin
      chk1("bus_entry_no_err", err_pulse, 1'b0);
      chk1("rgf_wr", rgf_wr, e.wr);
      chk32("rgf_sel", 32'(rgf_sel), 32'(e.sel));
      chk32("rgf_addr", 32'(rgf_addr), 32'(e.addr));
      chk32("rgf_wdata", rgf_wdata, e.wdata);
      n   = 0;
      bad = 1'b0;
      while (rgf_req === 1'b1 && n < 64) begin
        if (rgf_wr !== e.wr || rgf_sel !== e.sel || rgf_addr !== e.addr || rgf_wdata !== e.wdata)
          bad = 1'b1;
        rgf_ack   = (n == m.ack_dly);
        rgf_rdata = rgf_ack ? m.rdata : $urandom;
        step();
        n++;
        rgf_ack = 1'b0;
      end
      chk1("bus_fields_stable", bad, 1'b0);
      chk32("req_cycles", 32'(n), 32'(e.req_cycles));
      chk1("bus_exit_err_pulse", err_pulse, e.err);
      if (e.wr) chk1("write_ack_to_seq_ready", sys_seq_ready, 1'b1);
    end else begin
      chk1("decision_err_pulse", err_pulse, e.err);
      chk1("decision_seq_ready", sys_seq_ready, e.done);
    end
    chk1("rsp_valid", rsp_valid, e.resp);
    if (e.resp) begin
      chk32("rsp_data", rsp_data, e.rsp_data);
      chk1("rsp_err", rsp_err, e.rsp_err);
      d0  = rsp_data;
      r0  = rsp_err;
      bad = 1'b0;
      for (int i = 0; i < m.rdy_dly; i++) begin
        rsp_ready = 1'b0;
        step();
        if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_err !== r0 || sys_seq_ready !== 1'b0)
          bad = 1'b1;
      end
      chk1("rsp_hold", bad, 1'b0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk1("rsp_accept_valid_low", rsp_valid, 1'b0);
      chk1("rsp_accept_seq_ready", sys_seq_ready, 1'b1);
    end
    if (e.done) begin
      hold = int'($urandom_range(1, 3));
      bad  = 1'b0;
      for (int i = 0; i < hold; i++) begin
        rgf_ack = 1'($urandom);
        step();
        if (sys_seq_ready !== 1'b1 || rgf_req !== 1'b0) bad = 1'b1;
        if (i == 0) chk1("err_pulse_one_cycle", err_pulse, 1'b0);
      end
      rgf_ack = 1'b0;
      chk1("seq_ready_held", bad, 1'b0);
      sys_data_available = 1'b0;
      step();
      chk1("seq_ready_release", sys_seq_ready, 1'b0);
    end else begin
      sys_classified_type = MSG_REG_WRITE;
      sys_valid_msg       = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
        step();
        if (rgf_req !== 1'b0 || sys_seq_ready !== 1'b0) bad = 1'b1;
      end
      chk1("no_rearm_while_high", bad, 1'b0);
      sys_data_available = 1'b0;
      step();
    end
    if (e.err) model_err_cnt = (model_err_cnt == 255) ? 255 : model_err_cnt + 1;
    chk32("err_cnt", 32'(err_cnt), 32'(model_err_cnt));
  endtask

  vec_t tbl[12];

  initial begin
    msg_t m;
    tbl[0]  = '{'{MSG_REG_WRITE, 1'b1, 8'h02, 16'h0010, 16'h1234, 16'h5678, 3, 32'h0, 0},
                '{4, 1'b1, 32'h12345678, 8'h02, 16'h0010, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0}};
    tbl[1]  = '{'{MSG_REG_READ, 1'b1, 8'h05, 16'h0100, 16'h0000, 16'h0000, 0, 32'hCAFE0001, 5},
                '{1, 1'b0, 32'h0, 8'h05, 16'h0100, 1'b1, 32'hCAFE0001, 1'b0, 1'b1, 1'b0}};
    tbl[2]  = '{'{MSG_REG_READ, 1'b1, 8'h07, 16'hABCD, 16'h1111, 16'h2222, -1, 32'h0, 2},
                '{16, 1'b0, 32'h11112222, 8'h07, 16'hABCD, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1}};
    tbl[3]  = '{'{MSG_REG_WRITE, 1'b0, 8'h03, 16'h0004, 16'hAAAA, 16'hBBBB, 0, 32'h0, 0},
                '{0, 1'b0, 32'h0, 8'h00, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1}};
    tbl[4]  = '{'{MSG_PIXEL, 1'b1, 8'h02, 16'h0010, 16'h1234, 16'h5678, 0, 32'h0, 0},
                '{0, 1'b0, 32'h0, 8'h00, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0}};
    tbl[5]  = '{'{MSG_BURST, 1'b1, 8'h04, 16'h0008, 16'h0001, 16'h0002, 0, 32'h0, 0},
                '{0, 1'b0, 32'h0, 8'h00, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0}};
    tbl[6]  = '{'{MSG_NONE, 1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 0, 32'h0, 0},
                '{0, 1'b0, 32'h0, 8'h00, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0}};
    tbl[7]  = '{'{MSG_REG_WRITE, 1'b1, 8'h10, 16'h0020, 16'hFFFF, 16'h0001, 15, 32'h0, 0},
                '{16, 1'b1, 32'hFFFF0001, 8'h10, 16'h0020, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0}};
    tbl[8]  = '{'{MSG_REG_READ, 1'b1, 8'h11, 16'h0030, 16'h0000, 16'h0000, 15, 32'h0BADF00D, 1},
                '{16, 1'b0, 32'h0, 8'h11, 16'h0030, 1'b1, 32'h0BADF00D, 1'b0, 1'b1, 1'b0}};
    tbl[9]  = '{'{MSG_REG_WRITE, 1'b1, 8'h12, 16'h0040, 16'h0102, 16'h0304, -1, 32'h0, 0},
                '{16, 1'b1, 32'h01020304, 8'h12, 16'h0040, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1}};
    tbl[10] = '{'{MSG_REG_READ, 1'b0, 8'h20, 16'h0060, 16'h0000, 16'h0000, 0, 32'h0, 0},
                '{0, 1'b0, 32'h0, 8'h00, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1}};
    tbl[11] = '{'{MSG_REG_READ, 1'b1, 8'h13, 16'h0050, 16'h0000, 16'h0000, 16, 32'h12345678, 0},
                '{16, 1'b0, 32'h0, 8'h13, 16'h0050, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1}};

    rst_sys_n          = 1'b0;
    sys_data_available = 1'b0;
    rgf_ack            = 1'b0;
    rgf_rdata          = '0;
    rsp_ready          = 1'b0;
    scramble_inputs();
    repeat (3) step();
    tag = "reset";
    chk1("reset_rgf_req", rgf_req, 1'b0);
    chk1("reset_seq_ready", sys_seq_ready, 1'b0);
    chk32("reset_rsp_data", rsp_data, 32'h0);
    chk32("reset_err_cnt", 32'(err_cnt), 32'h0);
    chk32("reset_other_outputs", {rgf_wr, rgf_sel, rgf_addr, rsp_valid, rsp_err, err_pulse}, 32'h0);
    rst_sys_n = 1'b1;
    step();

    foreach (tbl[i]) begin
      tag = $sformatf("vec%0d", i);
      run_msg(tbl[i].m, tbl[i].e);
    end

    for (int i = 0; i < 60; i++) begin
      tag = $sformatf("rand%0d", i);
      m = rand_msg();
      run_msg(m, model(m));
    end

    tag = "reset_mid_bus";
    sys_classified_type    = MSG_REG_WRITE;
    sys_valid_msg          = 1'b1;
    sys_parsed_addr        = 8'h33;
    sys_parsed_offset_addr = 16'h0099;
    sys_parsed_data_high   = 16'hAAAA;
    sys_parsed_data_low    = 16'h5555;
    sys_data_available     = 1'b1;
    repeat (2) step();
    chk1("pre_reset_req", rgf_req, 1'b1);
    repeat (2) step();
    rst_sys_n = 1'b0;
    #1;
    chk1("rst_rgf_req", rgf_req, 1'b0);
    chk32("rst_rgf_wdata", rgf_wdata, 32'h0);
    chk32("rst_err_cnt", 32'(err_cnt), 32'h0);
    chk32("rst_other_outputs", {rgf_wr, rgf_sel, rgf_addr, rsp_valid, rsp_err, err_pulse, sys_seq_ready}, 32'h0);
    chk32("rst_rsp_data", rsp_data, 32'h0);
    sys_data_available = 1'b0;
    model_err_cnt      = 0;
    repeat (2) step();
    rst_sys_n = 1'b1;
    step();
    tag = "after_reset";
    run_msg(tbl[0].m, tbl[0].e);

    for (int i = 0; i < 260; i++) begin
      tag = $sformatf("sat%0d", i);
      run_msg(tbl[3].m, tbl[3].e);
    end
    tag = "saturation";
    chk32("err_cnt_saturated", 32'(err_cnt), 32'd255);
    run_msg(tbl[9].m, tbl[9].e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL [watchdog] simulation time limit: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/uart_reg_sequencer.md
UART_REG_SEQUENCER -- requirements
Module: uart_reg_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles to wait for rgf_ack after a request.
REQ-002 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned when a read times out.
REQ-003 clk_sys  in  1  system clock; single clock domain.
REQ-004 rst_sys_n  in  1  asynchronous, active-low reset.
REQ-005 sys_data_available  in  1  synchronized message-present level from the CDC stage.
REQ-006 sys_valid_msg  in  1  synchronized message-valid flag.
REQ-007 sys_classified_type  in  msg_type_e  message type.
REQ-008 sys_parsed_addr  in  8  RGF block select.
REQ-009 sys_parsed_offset_addr  in  16  register offset.
REQ-010 sys_parsed_data_high / sys_parsed_data_low  in  16 each  write data {high,low}.
REQ-011 sys_seq_ready  out  1  consumed-message level, returned to the RX domain.
REQ-012 rgf_req  out  1  bus request, held until ack or timeout.
REQ-013 rgf_wr  out  1  1 = write, 0 = read.
REQ-014 rgf_sel  out  8  block select; rgf_addr  out  16  offset; rgf_wdata  out  32  write data.
REQ-015 rgf_ack  in  1  single-cycle completion; rgf_rdata  in  32  read data, valid with ack.
REQ-016 rsp_valid  out  1  read response valid; rsp_data  out  32  response data; rsp_err  out  1  timeout flag; rsp_ready  in  1  TX accepts.
REQ-017 err_pulse  out  1  one-cycle error strobe; err_cnt  out  8  saturating error count.

Function
REQ-018 FSM states SHALL be IDLE, DECODE, BUS, RESP, DONE.
REQ-019 IDLE: sys_data_available=1 and sys_seq_ready=0 SHALL transition to DECODE on the next edge; inputs SHALL be registered into internal shadow regs in that same cycle.
REQ-020 DECODE, type MSG_REG_WRITE or MSG_REG_READ with sys_valid_msg=1: SHALL go to BUS and assert rgf_req the same cycle BUS is entered.
REQ-021 DECODE, register type with sys_valid_msg=0: SHALL go to DONE, one err_pulse, err_cnt+1.
REQ-022 DECODE, any other type (pixel, burst, MSG_NONE): SHALL return to IDLE without asserting sys_seq_ready and SHALL re-arm only after sys_data_available falls.
REQ-023 BUS: rgf_req, rgf_wr, rgf_sel, rgf_addr, rgf_wdata SHALL be stable until the ack cycle or timeout; rgf_wdata = {data_high,data_low}.
REQ-024 BUS, rgf_ack: write -> DONE; read -> capture rgf_rdata, go to RESP with rsp_err=0.
REQ-025 Timeout counter SHALL clear on BUS entry, increment each BUS cycle; reaching TIMEOUT_CYCLES without ack SHALL drop rgf_req, err_pulse, err_cnt+1; write -> DONE; read -> RESP with rsp_data=ERR_DATA, rsp_err=1.
REQ-026 Ack arriving on the timeout cycle SHALL take priority (success).
REQ-027 RESP: rsp_valid=1 with stable rsp_data/rsp_err until rsp_valid&&rsp_ready; then DONE.
REQ-028 DONE: sys_seq_ready=1, held until sys_data_available=0, then sys_seq_ready=0 next edge and IDLE (4-phase handshake).
REQ-029 rgf_ack outside BUS SHALL be ignored.
REQ-030 err_cnt SHALL saturate at 255; err_pulse still fires.
REQ-031 Latency: data_available rise to rgf_req = 2 cycles; write ack to sys_seq_ready = 1 cycle.

Reset
REQ-032 Reset SHALL force IDLE; all outputs 0, rsp_data 0, err_cnt 0, shadow regs 0, timeout counter 0; reset mid-transaction SHALL abandon it without an ack wait.

Structure
REQ-033 msg_type_e (incl. MSG_REG_WRITE, MSG_REG_READ) SHALL live in parser_pkg; the FSM state enum SHALL be local.
REQ-034 Single module; no sub-module.

Verification
REQ-035 Write type, sel 8'h02, offset 16'h0010, data 16'h1234/16'h5678, ack after 3 cycles -> rgf_wr=1, rgf_wdata 32'h12345678, sys_seq_ready 1 cycle after ack.
REQ-036 Read, ack with rdata 32'hCAFE0001, rsp_ready low 5 cycles -> rsp_valid held, rsp_data stable, sys_seq_ready only after accept.
REQ-037 Read, no ack, TIMEOUT_CYCLES=16 -> rgf_req drops after 16 cycles, rsp_data 32'hDEADBEEF, rsp_err=1, err_cnt=1.
REQ-038 Register type with sys_valid_msg=0 -> no rgf_req, err_pulse, sys_seq_ready asserted; pixel type -> no seq_ready.
REQ-039 Reset asserted mid-BUS -> all outputs 0 immediately; next message completes normally.
REQ-040 260 invalid messages -> err_cnt stays 255.
